// File: rtl/buf_meter_pkg.sv
// Shared constants and helpers for the buffer delay meter.
// Holds FSM state codes, default timing values and the trial-count decode.
package buf_meter_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRE    = 3'd1;
  localparam logic [2:0] ST_RISE   = 3'd2;
  localparam logic [2:0] ST_SET_HI = 3'd3;
  localparam logic [2:0] ST_FALL   = 3'd4;
  localparam logic [2:0] ST_SET_LO = 3'd5;
  localparam logic [2:0] ST_FINISH = 3'd6;

  localparam int SETTLE_DEF  = 16;
  localparam int TIMEOUT_DEF = 255;

  // A trial field of zero encodes the full count of 16.
  function automatic logic [4:0] eff_trials(input logic [3:0] t);
    return (t == 4'd0) ? 5'd16 : {1'b0, t};
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for one asynchronous bit.
// Ports: clk, rst (sync, active-high), d_i async input, q_o synchronized output.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/buf_delay_meter.sv
// Drives square-wave edges into the analog buffer and measures loop delay.
// Ports: clk/rst, start/trials request, stim_out drive, resp_in return,
// busy/done/timeout status, delay_last/min/max/sum and trial_cnt results.
module buf_delay_meter
  import buf_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF,
  parameter int SETTLE_CYC  = SETTLE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       trials,
  output logic             stim_out,
  input  logic             resp_in,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] delay_last,
  output logic [CNT_W-1:0] delay_min,
  output logic [CNT_W-1:0] delay_max,
  output logic [CNT_W+4:0] delay_sum,
  output logic [3:0]       trial_cnt
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic resp_s;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (resp_in),
    .q_o (resp_s)
  );

  logic [2:0]       st_q, st_d;
  logic             stim_q, stim_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [CNT_W+4:0] sum_q, sum_d;
  logic [3:0]       tcnt_q, tcnt_d;
  logic [4:0]       ntr_q, ntr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic             abort;

  always_comb begin
    st_d   = st_q;
    stim_d = stim_q;
    busy_d = busy_q;
    done_d = 1'b0;
    tmo_d  = tmo_q;
    last_d = last_q;
    min_d  = min_q;
    max_d  = max_q;
    sum_d  = sum_q;
    tcnt_d = tcnt_q;
    ntr_d  = ntr_q;
    cnt_d  = cnt_q;
    scnt_d = scnt_q;
    abort  = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (start) begin
          ntr_d  = eff_trials(trials);
          last_d = '0;
          min_d  = '1;
          max_d  = '0;
          sum_d  = '0;
          tcnt_d = '0;
          cnt_d  = '0;
          scnt_d = '0;
          tmo_d  = 1'b0;
          busy_d = 1'b1;
          stim_d = 1'b0;
          st_d   = ST_PRE;
        end
      end
      ST_PRE: begin
        // Require a clean low window on the return before the first edge.
        if (!resp_s && scnt_q == SET_LAST) begin
          st_d   = ST_RISE;
          stim_d = 1'b1;
          cnt_d  = '0;
          scnt_d = '0;
        end else if (cnt_q == TMO) begin
          abort = 1'b1;
        end else begin
          cnt_d  = cnt_q + ONE;
          scnt_d = resp_s ? '0 : scnt_q + ONE;
        end
      end
      ST_RISE, ST_FALL: begin
        if (resp_s == stim_q) begin
          last_d = cnt_q;
          if (cnt_q < min_q) min_d = cnt_q;
          if (cnt_q > max_q) max_d = cnt_q;
          sum_d  = sum_q + {5'd0, cnt_q};
          scnt_d = '0;
          st_d   = (st_q == ST_RISE) ? ST_SET_HI : ST_SET_LO;
        end else if (cnt_q == TMO) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_SET_HI: begin
        if (scnt_q == SET_LAST) begin
          st_d   = ST_FALL;
          stim_d = 1'b0;
          cnt_d  = '0;
        end else begin
          scnt_d = scnt_q + ONE;
        end
      end
      ST_SET_LO: begin
        if (scnt_q == SET_LAST) begin
          tcnt_d = tcnt_q + 4'd1;
          if ({1'b0, tcnt_q} + 5'd1 == ntr_q) begin
            st_d = ST_FINISH;
          end else begin
            st_d   = ST_RISE;
            stim_d = 1'b1;
            cnt_d  = '0;
          end
        end else begin
          scnt_d = scnt_q + ONE;
        end
      end
      ST_FINISH: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        st_d   = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
    if (abort) begin
      stim_d = 1'b0;
      tmo_d  = 1'b1;
      done_d = 1'b1;
      busy_d = 1'b0;
      st_d   = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      stim_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      tmo_q  <= 1'b0;
      last_q <= '0;
      min_q  <= '1;
      max_q  <= '0;
      sum_q  <= '0;
      tcnt_q <= '0;
      ntr_q  <= '0;
      cnt_q  <= '0;
      scnt_q <= '0;
    end else begin
      st_q   <= st_d;
      stim_q <= stim_d;
      busy_q <= busy_d;
      done_q <= done_d;
      tmo_q  <= tmo_d;
      last_q <= last_d;
      min_q  <= min_d;
      max_q  <= max_d;
      sum_q  <= sum_d;
      tcnt_q <= tcnt_d;
      ntr_q  <= ntr_d;
      cnt_q  <= cnt_d;
      scnt_q <= scnt_d;
    end
  end

  assign stim_out   = stim_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = tmo_q;
  assign delay_last = last_q;
  assign delay_min  = min_q;
  assign delay_max  = max_q;
  assign delay_sum  = sum_q;
  assign trial_cnt  = tcnt_q;

endmodule

// File: tb/tb_buf_delay_meter.sv
// Self-checking bench for buf_delay_meter.
// Loops stim_out back through a programmable rise/fall delay line.
module tb_buf_delay_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  trials = 4'd0;
  logic        stim_out;
  logic        resp_in;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [7:0]  dl;
  logic [7:0]  dmin;
  logic [7:0]  dmax;
  logic [12:0] dsum;
  logic [3:0]  tcnt;

  int checks = 0;
  int fails = 0;
  int dr = 0;
  int df = 0;
  bit stuck = 1'b0;
  logic [31:0] hist = '0;
  logic a_r;
  logic a_f;

  buf_delay_meter dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .trials     (trials),
    .stim_out   (stim_out),
    .resp_in    (resp_in),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .delay_last (dl),
    .delay_min  (dmin),
    .delay_max  (dmax),
    .delay_sum  (dsum),
    .trial_cnt  (tcnt)
  );

  always #5 clk = ~clk;

  // hist[k] holds stim_out as it was k+1 clock edges ago.
  always @(posedge clk) hist <= {hist[30:0], stim_out};

  always_comb begin
    a_r = (dr == 0) ? stim_out : hist[dr-1];
    a_f = (df == 0) ? stim_out : hist[df-1];
  end

  // Rising edges take dr cycles to return, falling edges take df cycles.
  assign resp_in = stuck ? 1'b0 : (stim_out ? a_r : a_f);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int limit);
    int k;
    k = 0;
    while (done !== 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic pulse_start(input logic [3:0] t);
    @(negedge clk);
    trials = t;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Reference: each trial yields a rise and a fall sample, each the
  // loop delay plus the two synchronizer flops.
  task automatic run(input string tag, input logic [3:0] t,
                     input int r, input int f, input int poke_at);
    int n;
    int q[$];
    int emin, emax, esum;
    n = (t == 4'd0) ? 16 : int'(t);
    for (int i = 0; i < n; i++) begin
      q.push_back(r + 2);
      q.push_back(f + 2);
    end
    emin = 255;
    emax = 0;
    esum = 0;
    foreach (q[i]) begin
      if (q[i] < emin) emin = q[i];
      if (q[i] > emax) emax = q[i];
      esum += q[i];
    end
    dr = r;
    df = f;
    pulse_start(t);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    if (poke_at > 0) begin
      repeat (poke_at) @(negedge clk);
      pulse_start(4'd1);
    end
    wait_done(tag, 6000);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_tmo"}, 32'(timeout), 32'd0);
    chk({tag, "_last"}, 32'(dl), 32'(q[$]));
    chk({tag, "_min"}, 32'(dmin), 32'(emin));
    chk({tag, "_max"}, 32'(dmax), 32'(emax));
    chk({tag, "_sum"}, 32'(dsum), 32'(esum));
    chk({tag, "_tcnt"}, 32'(tcnt), 32'(n % 16));
    chk({tag, "_stim"}, 32'(stim_out), 32'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_stim"}, 32'(stim_out), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_tmo"}, 32'(timeout), 32'd0);
    chk({tag, "_last"}, 32'(dl), 32'd0);
    chk({tag, "_min"}, 32'(dmin), 32'd255);
    chk({tag, "_max"}, 32'(dmax), 32'd0);
    chk({tag, "_sum"}, 32'(dsum), 32'd0);
    chk({tag, "_tcnt"}, 32'(tcnt), 32'd0);
  endtask

  initial begin
    int k;
    int seen;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("por");

    run("loop0", 4'd1, 0, 0, 0);
    run("loop5", 4'd3, 5, 5, 0);
    run("asym", 4'd2, 3, 9, 0);

    stuck = 1'b1;
    pulse_start(4'd4);
    wait_done("stuck", 2000);
    chk("stuck_tmo", 32'(timeout), 32'd1);
    chk("stuck_stim", 32'(stim_out), 32'd0);
    chk("stuck_busy", 32'(busy), 32'd0);
    chk("stuck_tcnt", 32'(tcnt), 32'd0);
    chk("stuck_sum", 32'(dsum), 32'd0);
    chk("stuck_min", 32'(dmin), 32'd255);
    stuck = 1'b0;
    repeat (5) @(negedge clk);

    run("t16", 4'd0, 0, 0, 100);

    for (int i = 0; i < 4; i++) begin
      run($sformatf("rnd%0d", i), 4'($urandom_range(1, 3)),
          int'($urandom_range(0, 12)), int'($urandom_range(0, 12)), 0);
    end

    dr = 8;
    df = 8;
    pulse_start(4'd2);
    k = 0;
    while (stim_out !== 1'b1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    while (stim_out !== 1'b0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("fall_reached", 32'(k < 500), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("midrst");
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    chk("midrst_nodone", 32'(seen), 32'd0);
    run("after_rst", 4'd2, 4, 1, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
